// File: rtl/vcache_wh_concentrator.sv
// Wormhole concentrator: funnels num_in_p request lanes onto one link, packet by packet,
// and steers returning response packets back to the lane named in the header cid.
module vcache_wh_concentrator #(
    parameter int num_in_p        = 4,
    parameter int wh_flit_width_p = 64,
    parameter int wh_cord_width_p = 7,
    parameter int wh_len_width_p  = 4,
    parameter int wh_cid_width_p  = 2
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [num_in_p-1:0]                  fwd_v_i,
    input  logic [num_in_p*wh_flit_width_p-1:0]  fwd_data_i,
    output logic [num_in_p-1:0]                  fwd_ready_o,
    output logic                                 fwd_v_o,
    output logic [wh_flit_width_p-1:0]           fwd_data_o,
    input  logic                                 fwd_ready_i,
    input  logic                                 rev_v_i,
    input  logic [wh_flit_width_p-1:0]           rev_data_i,
    output logic                                 rev_ready_o,
    output logic [num_in_p-1:0]                  rev_v_o,
    output logic [num_in_p*wh_flit_width_p-1:0]  rev_data_o,
    input  logic [num_in_p-1:0]                  rev_ready_i
);

    localparam int lg_lp      = $clog2(num_in_p);
    localparam int len_lsb_lp = wh_cord_width_p;
    localparam int cid_lsb_lp = wh_cord_width_p + wh_len_width_p;

    typedef enum logic [1:0] {F_IDLE, F_HOLD, F_BUSY} fwd_state_e;
    typedef enum logic {R_IDLE, R_BUSY} rev_state_e;

    function automatic logic [lg_lp-1:0] wrap_inc(input logic [lg_lp-1:0] x);
        if (x == lg_lp'(num_in_p - 1)) begin
            return '0;
        end
        return x + lg_lp'(1);
    endfunction

    logic [wh_flit_width_p-1:0] fwd_lane [num_in_p];

    for (genvar g = 0; g < num_in_p; g++) begin : g_lane
        assign fwd_lane[g] = fwd_data_i[g*wh_flit_width_p +: wh_flit_width_p];
    end

    fwd_state_e                fwd_state_q, fwd_state_d;
    logic [lg_lp-1:0]          rr_ptr_q, rr_ptr_d;
    logic [lg_lp-1:0]          fwd_grant_q, fwd_grant_d;
    logic [wh_len_width_p-1:0] fwd_cnt_q, fwd_cnt_d;

    logic [lg_lp-1:0]          rr_pick;
    logic                      rr_any;
    int                        rr_idx;
    logic [lg_lp-1:0]          fwd_sel;
    logic [wh_len_width_p-1:0] fwd_hdr_len;
    logic                      fwd_fire;

    // First requester at or after the pointer, wrapping around the lanes
    always_comb begin
        rr_pick = '0;
        rr_any  = 1'b0;
        rr_idx  = 0;
        for (int i = 0; i < num_in_p; i++) begin
            rr_idx = int'(rr_ptr_q) + i;
            if (rr_idx >= num_in_p) begin
                rr_idx = rr_idx - num_in_p;
            end
            if (!rr_any && fwd_v_i[lg_lp'(rr_idx)]) begin
                rr_any  = 1'b1;
                rr_pick = lg_lp'(rr_idx);
            end
        end
    end

    assign fwd_sel     = (fwd_state_q == F_IDLE) ? rr_pick : fwd_grant_q;
    assign fwd_hdr_len = fwd_lane[fwd_sel][len_lsb_lp +: wh_len_width_p];
    assign fwd_fire    = fwd_v_o & fwd_ready_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fwd_state_q <= F_IDLE;
            rr_ptr_q    <= '0;
            fwd_grant_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            fwd_state_q <= fwd_state_d;
            rr_ptr_q    <= rr_ptr_d;
            fwd_grant_q <= fwd_grant_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    always_comb begin
        fwd_state_d = fwd_state_q;
        rr_ptr_d    = rr_ptr_q;
        fwd_grant_d = fwd_grant_q;
        fwd_cnt_d   = fwd_cnt_q;
        unique case (fwd_state_q)
            F_IDLE, F_HOLD: begin
                if (fwd_fire) begin
                    if (fwd_hdr_len == '0) begin
                        rr_ptr_d    = wrap_inc(fwd_sel);
                        fwd_state_d = F_IDLE;
                    end else begin
                        fwd_cnt_d   = fwd_hdr_len;
                        fwd_grant_d = fwd_sel;
                        fwd_state_d = F_BUSY;
                    end
                end else if (fwd_v_o) begin
                    // An offered header is frozen so the output never changes under a stall
                    fwd_grant_d = fwd_sel;
                    fwd_state_d = F_HOLD;
                end
            end
            F_BUSY: begin
                if (fwd_fire) begin
                    fwd_cnt_d = fwd_cnt_q - wh_len_width_p'(1);
                    if (fwd_cnt_q == wh_len_width_p'(1)) begin
                        rr_ptr_d    = wrap_inc(fwd_grant_q);
                        fwd_state_d = F_IDLE;
                    end
                end
            end
            default: fwd_state_d = F_IDLE;
        endcase
    end

    always_comb begin
        fwd_v_o     = 1'b0;
        fwd_data_o  = fwd_lane[fwd_sel];
        fwd_ready_o = '0;
        if (!reset_i) begin
            fwd_v_o = fwd_v_i[fwd_sel];
            if (fwd_state_q != F_IDLE || rr_any) begin
                fwd_ready_o[fwd_sel] = fwd_ready_i;
            end
        end
    end

    rev_state_e                rev_state_q, rev_state_d;
    logic [lg_lp-1:0]          rev_tgt_q, rev_tgt_d;
    logic [wh_len_width_p-1:0] rev_cnt_q, rev_cnt_d;

    logic [wh_cid_width_p-1:0] rev_cid;
    logic [lg_lp-1:0]          rev_sel;
    logic [wh_len_width_p-1:0] rev_hdr_len;
    logic                      rev_fire;

    assign rev_cid     = rev_data_i[cid_lsb_lp +: wh_cid_width_p];
    assign rev_sel     = (rev_state_q == R_IDLE) ? rev_cid[lg_lp-1:0] : rev_tgt_q;
    assign rev_hdr_len = rev_data_i[len_lsb_lp +: wh_len_width_p];
    assign rev_fire    = rev_v_i & rev_ready_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rev_state_q <= R_IDLE;
            rev_tgt_q   <= '0;
            rev_cnt_q   <= '0;
        end else begin
            rev_state_q <= rev_state_d;
            rev_tgt_q   <= rev_tgt_d;
            rev_cnt_q   <= rev_cnt_d;
        end
    end

    always_comb begin
        rev_state_d = rev_state_q;
        rev_tgt_d   = rev_tgt_q;
        rev_cnt_d   = rev_cnt_q;
        unique case (rev_state_q)
            R_IDLE: begin
                if (rev_fire && rev_hdr_len != '0) begin
                    rev_tgt_d   = rev_sel;
                    rev_cnt_d   = rev_hdr_len;
                    rev_state_d = R_BUSY;
                end
            end
            R_BUSY: begin
                if (rev_fire) begin
                    rev_cnt_d = rev_cnt_q - wh_len_width_p'(1);
                    if (rev_cnt_q == wh_len_width_p'(1)) begin
                        rev_state_d = R_IDLE;
                    end
                end
            end
            default: rev_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        rev_v_o     = '0;
        rev_ready_o = 1'b0;
        rev_data_o  = {num_in_p{rev_data_i}};
        if (!reset_i) begin
            rev_v_o[rev_sel] = rev_v_i;
            rev_ready_o      = rev_ready_i[rev_sel];
        end
    end

endmodule

// File: tb/tb_vcache_wh_concentrator.sv
// Randomised and directed bench for vcache_wh_concentrator against a
// packet-level model of lane ownership and response steering.
module tb_vcache_wh_concentrator;

    localparam int N       = 4;
    localparam int W       = 64;
    localparam int CORD    = 7;
    localparam int LENW    = 4;
    localparam int CIDW    = 2;
    localparam int LEN_LSB = CORD;
    localparam int CID_LSB = CORD + LENW;

    logic           clk = 1'b0;
    logic           reset_i;
    logic [N-1:0]   fwd_v_i;
    logic [N*W-1:0] fwd_data_i;
    logic [N-1:0]   fwd_ready_o;
    logic           fwd_v_o;
    logic [W-1:0]   fwd_data_o;
    logic           fwd_ready_i;
    logic           rev_v_i;
    logic [W-1:0]   rev_data_i;
    logic           rev_ready_o;
    logic [N-1:0]   rev_v_o;
    logic [N*W-1:0] rev_data_o;
    logic [N-1:0]   rev_ready_i;

    always #5 clk = ~clk;

    vcache_wh_concentrator #(
        .num_in_p(N), .wh_flit_width_p(W), .wh_cord_width_p(CORD),
        .wh_len_width_p(LENW), .wh_cid_width_p(CIDW)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .fwd_v_i(fwd_v_i), .fwd_data_i(fwd_data_i), .fwd_ready_o(fwd_ready_o),
        .fwd_v_o(fwd_v_o), .fwd_data_o(fwd_data_o), .fwd_ready_i(fwd_ready_i),
        .rev_v_i(rev_v_i), .rev_data_i(rev_data_i), .rev_ready_o(rev_ready_o),
        .rev_v_o(rev_v_o), .rev_data_o(rev_data_o), .rev_ready_i(rev_ready_i)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Upstream traffic: per-lane flit queues with header markers
    logic [W-1:0] lq [N][$];
    bit           lh [N][$];
    int           lgap [N];
    logic [W-1:0] rq [$];
    bit           rh [$];
    int           rgap;
    int           gap_max;
    int           serial;

    // Model: lane owning the output (-1 none), flits left, round-robin start
    int ptr, owner, remain;
    int rowner, rremain;

    int hdr_log [$];
    int rev_obs [N];
    int obs_lane;

    task automatic push_pkt(input int lane, input int len, input int cid);
        logic [W-1:0] f;
        for (int k = 0; k <= len; k++) begin
            f = {$urandom, $urandom};
            f[63:60] = 4'(lane);
            f[59:52] = 8'(serial);
            f[51:48] = 4'(k);
            if (k == 0) begin
                f[LEN_LSB +: LENW] = LENW'(len);
                f[CID_LSB +: CIDW] = CIDW'(cid);
            end
            if (lane < N) begin
                lq[lane].push_back(f);
                lh[lane].push_back(k == 0);
            end else begin
                rq.push_back(f);
                rh.push_back(k == 0);
            end
        end
        serial++;
    endtask

    function automatic bit busy();
        for (int l = 0; l < N; l++) if (lq[l].size() > 0) return 1'b1;
        return rq.size() > 0;
    endfunction

    task automatic step();
        bit           v [N];
        int           sel;
        bit           ev, ffire, rv, rfire;
        int           tgt;
        logic [W-1:0] hf;
        logic [N-1:0] er, rmask, erv;
        for (int l = 0; l < N; l++) begin
            v[l] = lq[l].size() > 0 && lgap[l] == 0;
            fwd_v_i[l] = v[l];
            fwd_data_i[l*W +: W] = v[l] ? lq[l][0] : '0;
        end
        rv = rq.size() > 0 && rgap == 0;
        rev_v_i = rv;
        rev_data_i = rv ? rq[0] : '0;
        sel = -1; ev = 0; ffire = 0; rfire = 0; tgt = 0;
        @(negedge clk);
        obs_lane = int'(fwd_data_o[63:60]);
        for (int l = 0; l < N; l++) if (rev_v_o[l] && rev_ready_i[l]) rev_obs[l]++;
        if (reset_i) begin
            chk("rst_fwd_v", fwd_v_o, 0);
            chk("rst_fwd_ready", fwd_ready_o, 0);
            chk("rst_rev_v", rev_v_o, 0);
            chk("rst_rev_ready", rev_ready_o, 0);
        end else begin
            sel = owner;
            if (sel < 0) begin
                for (int i = 0; i < N; i++) begin
                    if (sel < 0 && v[(ptr + i) % N]) sel = (ptr + i) % N;
                end
            end
            ev = sel >= 0 && v[sel];
            chk("fwd_v", fwd_v_o, ev);
            if (ev) chk("fwd_data", fwd_data_o, lq[sel][0]);
            er = '0;
            rmask = '1;
            if (sel >= 0) begin
                er[sel] = ev & fwd_ready_i;
                if (!ev) rmask[sel] = 1'b0;
            end
            chk("fwd_ready", fwd_ready_o & rmask, er);
            ffire = ev && fwd_ready_i;
            if (ffire && lh[sel][0]) hdr_log.push_back(int'(fwd_data_o[63:60]));
            if (rv) begin
                hf = rq[0];
                if (rowner < 0) begin
                    assert (int'(hf[CID_LSB +: CIDW]) < N) else $error("illegal response cid");
                    tgt = int'(hf[CID_LSB +: CIDW]);
                end else begin
                    tgt = rowner;
                end
                erv = '0;
                erv[tgt] = 1'b1;
                chk("rev_v", rev_v_o, erv);
                chk("rev_ready", rev_ready_o, rev_ready_i[tgt]);
                chk("rev_data", rev_data_o[tgt*W +: W], hf);
                chk("rev_bcast", rev_data_o[((tgt + 1) % N)*W +: W], hf);
                rfire = rev_ready_i[tgt];
            end else begin
                chk("rev_v_idle", rev_v_o, 0);
            end
        end
        @(posedge clk);
        #1;
        for (int l = 0; l < N; l++) if (lgap[l] > 0) lgap[l]--;
        if (rgap > 0) rgap--;
        if (reset_i) begin
            owner = -1; ptr = 0; rowner = -1;
            for (int l = 0; l < N; l++) begin
                while (lq[l].size() > 0 && !lh[l][0]) begin
                    void'(lq[l].pop_front());
                    void'(lh[l].pop_front());
                end
            end
            while (rq.size() > 0 && !rh[0]) begin
                void'(rq.pop_front());
                void'(rh.pop_front());
            end
        end else begin
            if (ev && owner < 0) begin
                hf = lq[sel][0];
                owner = sel;
                remain = int'(hf[LEN_LSB +: LENW]) + 1;
            end
            if (ffire) begin
                void'(lq[sel].pop_front());
                void'(lh[sel].pop_front());
                remain--;
                if (remain == 0) begin
                    ptr = (owner + 1) % N;
                    owner = -1;
                    lgap[sel] = gap_max > 0 ? int'($urandom_range(0, gap_max)) : 0;
                end
            end
            if (rfire) begin
                hf = rq[0];
                if (rowner < 0) begin
                    rowner = tgt;
                    rremain = int'(hf[LEN_LSB +: LENW]) + 1;
                end
                void'(rq.pop_front());
                void'(rh.pop_front());
                rremain--;
                if (rremain == 0) begin
                    rowner = -1;
                    rgap = gap_max > 0 ? int'($urandom_range(0, gap_max)) : 0;
                end
            end
        end
    endtask

    task automatic drain(input int maxc, output int cyc);
        cyc = 0;
        fwd_ready_i = 1'b1;
        rev_ready_i = '1;
        while (busy() && cyc < maxc) begin
            step();
            cyc++;
        end
        chk("drain_timeout", busy(), 0);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
    endtask

    int cyc;
    int exp_b [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        reset_i = 1'b1; fwd_ready_i = 1'b1; rev_ready_i = '0;
        fwd_v_i = '0; fwd_data_i = '0; rev_v_i = 1'b0; rev_data_i = '0;
        ptr = 0; owner = -1; remain = 0; rowner = -1; rremain = 0;
        rgap = 0; gap_max = 0; serial = 0; obs_lane = 0;
        for (int l = 0; l < N; l++) begin lgap[l] = 0; rev_obs[l] = 0; end

        // Reset with all lanes requesting, then round-robin of len=2 packets
        for (int l = 0; l < N; l++) push_pkt(l, 2, 0);
        repeat (3) step();
        reset_i = 1'b0;
        hdr_log.delete();
        for (int c = 0; c < 24; c++) begin
            for (int l = 0; l < N; l++) if (lq[l].size() < 6) push_pkt(l, 2, 0);
            step();
        end
        chk("rr_count", hdr_log.size(), 8);
        for (int i = 0; i < 8 && i < hdr_log.size(); i++) chk("rr_order", hdr_log[i], exp_b[i]);
        drain(200, cyc);

        // Stalled lane 2 header holds the output while lane 1 waits
        do_reset();
        hdr_log.delete();
        fwd_ready_i = 1'b0;
        push_pkt(2, 2, 0);
        step();
        push_pkt(1, 0, 0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("hold_lane", obs_lane, 2);
        end
        drain(50, cyc);
        chk("hold_cnt", hdr_log.size(), 2);
        if (hdr_log.size() == 2) begin
            chk("hold_first", hdr_log[0], 2);
            chk("hold_second", hdr_log[1], 1);
        end

        // Back-to-back single-flit packets from lanes 1 and 3
        do_reset();
        hdr_log.delete();
        fwd_ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (lq[1].size() < 2) push_pkt(1, 0, 0);
            if (lq[3].size() < 2) push_pkt(3, 0, 0);
            step();
        end
        chk("alt_rate", hdr_log.size(), 8);
        for (int i = 0; i < 8 && i < hdr_log.size(); i++) chk("alt_order", hdr_log[i], (i % 2) ? 3 : 1);
        drain(50, cyc);

        // Single requester gets every packet with no bubble
        do_reset();
        for (int i = 0; i < 3; i++) push_pkt(0, 1, 0);
        drain(50, cyc);
        chk("single_cycles", cyc, 6);

        // Max-length response to lane 2 with a toggling ready
        do_reset();
        for (int l = 0; l < N; l++) rev_obs[l] = 0;
        push_pkt(N, 15, 2);
        cyc = 0;
        while (rq.size() > 0 && cyc < 100) begin
            rev_ready_i = N'($urandom);
            rev_ready_i[2] = cyc[0];
            step();
            cyc++;
        end
        chk("rev_timeout", rq.size(), 0);
        for (int l = 0; l < N; l++) chk("rev_lane_flits", rev_obs[l], (l == 2) ? 16 : 0);

        // Reset in the middle of a lane-1 packet and a response packet
        do_reset();
        fwd_ready_i = 1'b1;
        rev_ready_i = '1;
        push_pkt(1, 0, 0);
        push_pkt(1, 4, 0);
        push_pkt(N, 6, 1);
        cyc = 0;
        while (lq[1].size() != 3 && cyc < 30) begin
            step();
            cyc++;
        end
        chk("mid_timeout", lq[1].size(), 3);
        hdr_log.delete();
        do_reset();
        push_pkt(3, 3, 0);
        push_pkt(0, 0, 0);
        drain(50, cyc);
        chk("post_rst_cnt", hdr_log.size(), 2);
        if (hdr_log.size() == 2) begin
            chk("post_rst_first", hdr_log[0], 0);
            chk("post_rst_second", hdr_log[1], 3);
        end

        // Random traffic on both paths
        gap_max = 3;
        for (int c = 0; c < 3000; c++) begin
            fwd_ready_i = ($urandom % 4) != 0;
            rev_ready_i = N'($urandom);
            for (int l = 0; l < N; l++) begin
                if (lq[l].size() < 4)
                    push_pkt(l, ($urandom % 8 == 0) ? 15 : int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
            end
            if (rq.size() < 4)
                push_pkt(N, ($urandom % 8 == 0) ? 15 : int'($urandom_range(0, 5)), int'($urandom_range(0, N - 1)));
            reset_i = (c == 1500 || c == 1501);
            step();
        end
        reset_i = 1'b0;
        gap_max = 0;
        drain(1000, cyc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
